// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and LFSR constants for the Memory Matrix board generator.
package mm_pkg;
  typedef enum logic [1:0] {IDLE, GEN, SHOW, ARMED} state_t;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int TILES = 16;
endpackage

// File: rtl/mm_lfsr16.sv
// mm_lfsr16: 16-bit Galois LFSR with seed load (zero seed falls back to the default) and step enable.
module mm_lfsr16 import mm_pkg::*; #(
  parameter logic [15:0] SEED0 = mm_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);
  always_ff @(posedge clk)
    if (reset) value <= SEED0;
    else if (load) value <= seed == 16'd0 ? SEED0 : seed;
    else if (step) value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 16'd0);
endmodule

// File: rtl/board_generator.sv
// board_generator: places N distinct lit tiles via LFSR, shows them for SHOW_CYCLES, then arms guessing.
module board_generator import mm_pkg::*; #(
  parameter int          TILES        = mm_pkg::TILES,
  parameter int          SHOW_CYCLES  = 100000000,
  parameter logic [15:0] DEFAULT_SEED = mm_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [4:0]       tiles_req,
  output logic [TILES-1:0] board,
  output logic [TILES-1:0] show,
  output logic             busy,
  output logic             guess_enable,
  output logic             done
);
  localparam int IW = $clog2(TILES);
  localparam int TW = $clog2(SHOW_CYCLES + 1);
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [IW-1:0] idx;
  logic [4:0] cnt, target, target_c;
  logic [TW-1:0] timer;
  logic accept, place;
  mm_lfsr16 #(.SEED0(DEFAULT_SEED)) u_lfsr (
    .clk(clk), .reset(reset), .load(seed_load), .seed(seed),
    .step(state == GEN), .value(lfsr)
  );
  assign idx = IW'(lfsr & 16'(TILES - 1));
  assign accept = start && (state == IDLE || state == ARMED);
  assign place = state == GEN && cnt != target && !board[idx];
  assign target_c = tiles_req == 5'd0 ? 5'd1 : tiles_req > 5'(TILES) ? 5'(TILES) : tiles_req;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = accept ? GEN
            : state == GEN && cnt == target ? SHOW
            : state == SHOW && timer == '0 ? ARMED
            : state;
    show = state == SHOW ? board : '0;
    busy = state == GEN || state == SHOW;
    guess_enable = state == ARMED;
  end
  always_ff @(posedge clk)
    if (reset) begin
      board  <= '0;
      cnt    <= '0;
      target <= '0;
      timer  <= '0;
      done   <= 1'b0;
    end else begin
      done <= state == SHOW && timer == '0;
      if (accept) begin
        board  <= '0;
        cnt    <= '0;
        target <= target_c;
      end else if (place) begin
        board[idx] <= 1'b1;
        cnt        <= cnt + 5'd1;
      end
      timer <= state == GEN && cnt == target ? TW'(SHOW_CYCLES - 1)
             : state == SHOW && timer != '0 ? timer - TW'(1)
             : timer;
    end
endmodule

// File: tb/tb_board_generator.sv
// tb_board_generator: random and directed rounds checked against a behavioural placement model.
module tb_board_generator;
  import mm_pkg::*;
  localparam int SC = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [4:0] tiles_req = '0;
  logic [15:0] board, show;
  logic busy, guess_enable, done;
  int compared = 0, mismatched = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] last_board, b_default;

  board_generator #(.TILES(16), .SHOW_CYCLES(SC), .DEFAULT_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed(seed),
    .tiles_req(tiles_req), .board(board), .show(show), .busy(busy),
    .guess_enable(guess_enable), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Keep drawing indices until target distinct tiles are lit, then one more (check) cycle.
  task automatic gen_model(input logic [15:0] l0, input int tgt, output logic [15:0] b,
                           output int cyc, output logic [15:0] lf, output int rej);
    logic [15:0] l = l0;
    int i;
    b = '0; cyc = 1; rej = 0;
    while ($countones(b) < tgt) begin
      i = int'(l % 16);
      if (b[i]) rej++;
      else b[i] = 1'b1;
      l = lstep(l);
      cyc++;
    end
    lf = lstep(l);
  endtask

  task automatic do_round(input logic [4:0] req, input bit poke, input bit with_seed, input logic [15:0] sd);
    logic [15:0] eb, nl;
    int ecyc, rej, tgt, gn, sn;
    @(negedge clk);
    start = 1'b1; tiles_req = req; seed_load = with_seed; seed = sd;
    if (with_seed) m_lfsr = sd == 16'd0 ? 16'hACE1 : sd;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    tgt = req == 0 ? 1 : req > 16 ? 16 : int'(req);
    gen_model(m_lfsr, tgt, eb, ecyc, nl, rej);
    m_lfsr = nl;
    check("gen_clear", {board, 15'd0, busy}, {16'd0, 15'd0, 1'b1});
    gn = 0;
    while (busy && show == '0 && gn < 5000) begin
      gn++;
      start = poke;
      @(negedge clk);
    end
    check("gen_cycles", gn, ecyc);
    sn = 0;
    while (show != '0 && sn < 100) begin
      check("show_eq_board", {show, 15'd0, busy}, {board, 15'd0, 1'b1});
      sn++;
      start = poke;
      @(negedge clk);
    end
    start = 1'b0;
    check("show_cycles", sn, SC);
    check("board", board, eb);
    check("popcount", $countones(board), tgt);
    check("armed", {show, 13'd0, done, guess_enable, busy}, {16'd0, 13'd0, 3'b110});
    last_board = board;
    @(negedge clk);
    check("done_once", {done, guess_enable}, 2'b01);
    check("board_held", board, eb);
  endtask

  initial begin
    int gn;
    repeat (2) @(negedge clk);
    check("reset_outs", {board, show}, 32'd0);
    check("reset_flags", {busy, guess_enable, done}, 3'b000);
    check("reset_lfsr", dut.lfsr, 16'hACE1);
    reset = 1'b0;
    do_round(5'd4, 1'b0, 1'b0, 16'h0);
    b_default = last_board;
    // Seed 1 yields indices 1,0,0,... so a duplicate is rejected.
    @(negedge clk);
    seed_load = 1'b1; seed = 16'h0001;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 16'h0001;
    do_round(5'd3, 1'b0, 1'b0, 16'h0);
    do_round(5'd0, 1'b0, 1'b0, 16'h0);
    do_round(5'd20, 1'b0, 1'b0, 16'h0);
    check("full_board", board, 16'hFFFF);
    do_round(5'd6, 1'b1, 1'b0, 16'h0);
    do_round(5'd2, 1'b0, 1'b1, 16'h1234);
    for (int r = 0; r < 8; r++)
      do_round(5'($urandom_range(0, 20)), 1'($urandom % 2), 1'($urandom % 2), 16'($urandom));
    @(negedge clk);
    start = 1'b1; tiles_req = 5'd7;
    @(negedge clk);
    start = 1'b0;
    gn = 0;
    while (show == '0 && gn < 5000) begin
      gn++;
      @(negedge clk);
    end
    check("reach_show", {15'd0, show != '0}, 16'd1);
    repeat (4) @(negedge clk);
    check("timer_at_3", 32'(dut.timer), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outs", {board, show}, 32'd0);
    check("abort_flags", {busy, guess_enable, done}, 3'b000);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_lfsr", dut.lfsr, 16'hACE1);
    m_lfsr = 16'hACE1;
    do_round(5'd5, 1'b0, 1'b0, 16'h0);
    b_default = last_board;
    @(negedge clk);
    seed_load = 1'b1; seed = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    do_round(5'd5, 1'b0, 1'b0, 16'h0);
    check("zero_seed_default", last_board, b_default);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
